// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the cpu run-control sequencer.
// Holds state and halt-cause encodings plus small state-decoding helpers.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } run_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_HALT  = 2'b01,
      CAUSE_LIMIT = 2'b10,
      CAUSE_ABORT = 2'b11
   } halt_cause_t;

   localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;
   localparam logic [31:0] NOP_INSTR       = 32'h0;

   // Pipeline advances only while executing or draining.
   function automatic logic state_enables(input run_state_t s);
      return (s == ST_RUN) || (s == ST_DRAIN);
   endfunction

   function automatic logic state_busy(input run_state_t s);
      return (s == ST_RUN) || (s == ST_PAUSE) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: starts/halts/drains the pipeline and arbitrates host
// access to the memory ports by freezing the pipeline before granting.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int         CNT_W        = 32,
   parameter int         DRAIN_CYCLES = 4,
   parameter logic [5:0] HALT_OPCODE  = HALT_OPCODE_DEF
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic [31:0]      instruction,
   input  logic             ext_req,
   output logic             cpu_enable,
   output logic             fetch_squash,
   output logic             ext_gnt,
   output logic             busy,
   output logic             done,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] cycle_count,
   output run_state_t       dbg_state
);

   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

   run_state_t       state_q, state_d;
   halt_cause_t      cause_q, cause_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [DCW-1:0]   drain_q, drain_d;
   logic             ext_gnt_q, ext_gnt_d;

   logic             start_ok;
   logic             halt_seen;
   logic             limit_hit;
   logic [CNT_W-1:0] count;
   logic             unused_instr_lo;

   assign unused_instr_lo = ^instruction[25:0];
   assign halt_seen       = (instruction[31:26] == HALT_OPCODE);
   assign start_ok        = start && !ext_req
                            && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   // Drain begins after exactly max_q RUN cycles; max_q == 0 disables the limit.
   assign limit_hit       = (max_q != '0) && ((count + CNT_W'(1)) == max_q);

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .en     (cpu_enable),
      .clr    (start_ok),
      .count  (count)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= ST_IDLE;
         cause_q   <= CAUSE_NONE;
         max_q     <= '0;
         drain_q   <= '0;
         ext_gnt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         max_q     <= max_d;
         drain_q   <= drain_d;
         ext_gnt_q <= ext_gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      max_d   = max_q;
      drain_d = drain_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_d = ST_RUN;
               cause_d = CAUSE_NONE;
               max_d   = max_cycles;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_DONE;
               cause_d = CAUSE_ABORT;
            end else if (halt_seen) begin
               state_d = ST_DRAIN;
               cause_d = CAUSE_HALT;
               drain_d = DRAIN_LOAD;
            end else if (limit_hit) begin
               state_d = ST_DRAIN;
               cause_d = CAUSE_LIMIT;
               drain_d = DRAIN_LOAD;
            end else if (ext_req) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (abort) begin
               state_d = ST_DONE;
               cause_d = CAUSE_ABORT;
            end else if (!ext_req) begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_d = ST_DONE;
               cause_d = CAUSE_ABORT;
            end else if (drain_q == '0) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q - DCW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Grant is registered: mirrors ext_req while stopped, forced on while paused.
      if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
         ext_gnt_d = ext_req;
      end else begin
         ext_gnt_d = (state_d == ST_PAUSE);
      end
   end

   always_comb begin
      cpu_enable   = state_enables(state_q);
      fetch_squash = (state_q == ST_DRAIN);
      busy         = state_busy(state_q);
      done         = (state_q == ST_DONE);
      ext_gnt      = ext_gnt_q;
      halt_cause   = cause_q;
      cycle_count  = count;
      dbg_state    = state_q;
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: halt, cycle limit, pause, abort, idle
// arbitration and asynchronous reset, with hand-computed expectations.
module tb_cpu_run_ctrl;
   import cpu_ctrl_pkg::*;

   localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

   logic        clk;
   logic        arst_n;
   logic        start;
   logic        abort;
   logic [31:0] max_cycles;
   logic [31:0] instruction;
   logic        ext_req;
   logic        cpu_enable;
   logic        fetch_squash;
   logic        ext_gnt;
   logic        busy;
   logic        done;
   logic [1:0]  halt_cause;
   logic [31:0] cycle_count;
   run_state_t  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   cpu_run_ctrl #(
      .CNT_W        (32),
      .DRAIN_CYCLES (4),
      .HALT_OPCODE  (6'h3F)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .start        (start),
      .abort        (abort),
      .max_cycles   (max_cycles),
      .instruction  (instruction),
      .ext_req      (ext_req),
      .cpu_enable   (cpu_enable),
      .fetch_squash (fetch_squash),
      .ext_gnt      (ext_gnt),
      .busy         (busy),
      .done         (done),
      .halt_cause   (halt_cause),
      .cycle_count  (cycle_count),
      .dbg_state    (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected outputs are derived from the expected state, grant, cause and count.
   task automatic exp_all(input string tag, input run_state_t st, input logic gnt,
                          input halt_cause_t cause, input logic [31:0] cnt);
      logic e_en, e_busy;
      e_en   = (st == ST_RUN) || (st == ST_DRAIN);
      e_busy = (st == ST_RUN) || (st == ST_PAUSE) || (st == ST_DRAIN);
      chk({tag, ".state"},  32'(dbg_state),    32'(st));
      chk({tag, ".enable"}, 32'(cpu_enable),   32'(e_en));
      chk({tag, ".squash"}, 32'(fetch_squash), 32'(st == ST_DRAIN));
      chk({tag, ".gnt"},    32'(ext_gnt),      32'(gnt));
      chk({tag, ".busy"},   32'(busy),         32'(e_busy));
      chk({tag, ".done"},   32'(done),         32'(st == ST_DONE));
      chk({tag, ".cause"},  32'(halt_cause),   32'(cause));
      chk({tag, ".count"},  cycle_count,       cnt);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] max);
      max_cycles = max;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   initial begin
      arst_n      = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      max_cycles  = '0;
      instruction = NOP_INSTR;
      ext_req     = 1'b0;
      #12;
      exp_all("rst", ST_IDLE, 1'b0, CAUSE_NONE, 0);
      @(negedge clk);
      arst_n = 1'b1;
      step();
      exp_all("idle", ST_IDLE, 1'b0, CAUSE_NONE, 0);

      // HALT seen in the third RUN cycle: 3 RUN + 4 DRAIN enabled cycles.
      do_start(0);
      exp_all("h.run0", ST_RUN, 1'b0, CAUSE_NONE, 0);
      step();
      exp_all("h.run1", ST_RUN, 1'b0, CAUSE_NONE, 1);
      step();
      exp_all("h.run2", ST_RUN, 1'b0, CAUSE_NONE, 2);
      instruction = HALT_WORD;
      step();
      instruction = NOP_INSTR;
      exp_all("h.drain0", ST_DRAIN, 1'b0, CAUSE_HALT, 3);
      for (int i = 0; i < 3; i++) begin
         step();
         exp_all("h.drain", ST_DRAIN, 1'b0, CAUSE_HALT, 32'(4 + i));
      end
      step();
      exp_all("h.done", ST_DONE, 1'b0, CAUSE_HALT, 7);
      step();
      exp_all("h.hold", ST_DONE, 1'b0, CAUSE_HALT, 7);

      // Cycle limit of 10: 10 RUN + 4 DRAIN cycles.
      do_start(10);
      exp_all("l.run0", ST_RUN, 1'b0, CAUSE_NONE, 0);
      for (int i = 1; i < 10; i++) begin
         step();
         exp_all("l.run", ST_RUN, 1'b0, CAUSE_NONE, 32'(i));
      end
      step();
      exp_all("l.drain0", ST_DRAIN, 1'b0, CAUSE_LIMIT, 10);
      for (int i = 0; i < 3; i++) begin
         step();
         exp_all("l.drain", ST_DRAIN, 1'b0, CAUSE_LIMIT, 32'(11 + i));
      end
      step();
      exp_all("l.done", ST_DONE, 1'b0, CAUSE_LIMIT, 14);

      // Smallest nonzero limit: a single RUN cycle.
      do_start(1);
      exp_all("l1.run0", ST_RUN, 1'b0, CAUSE_NONE, 0);
      step();
      exp_all("l1.drain0", ST_DRAIN, 1'b0, CAUSE_LIMIT, 1);
      repeat (3) step();
      step();
      exp_all("l1.done", ST_DONE, 1'b0, CAUSE_LIMIT, 5);

      // Pause for host access at count 5, then abort in the second DRAIN cycle.
      do_start(0);
      exp_all("p.run0", ST_RUN, 1'b0, CAUSE_NONE, 0);
      repeat (5) step();
      exp_all("p.run5", ST_RUN, 1'b0, CAUSE_NONE, 5);
      ext_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         exp_all("p.pause", ST_PAUSE, 1'b1, CAUSE_NONE, 6);
      end
      ext_req = 1'b0;
      step();
      exp_all("p.resume", ST_RUN, 1'b0, CAUSE_NONE, 6);
      step();
      exp_all("p.run7", ST_RUN, 1'b0, CAUSE_NONE, 7);
      instruction = HALT_WORD;
      step();
      instruction = NOP_INSTR;
      exp_all("a.drain1", ST_DRAIN, 1'b0, CAUSE_HALT, 8);
      step();
      exp_all("a.drain2", ST_DRAIN, 1'b0, CAUSE_HALT, 9);
      abort = 1'b1;
      step();
      exp_all("a.done", ST_DONE, 1'b0, CAUSE_ABORT, 10);
      step();
      exp_all("a.ignored", ST_DONE, 1'b0, CAUSE_ABORT, 10);
      abort = 1'b0;

      // Host arbitration while stopped: start is refused while ext_req is high.
      ext_req = 1'b1;
      exp_all("arb.lat", ST_DONE, 1'b0, CAUSE_ABORT, 10);
      step();
      exp_all("arb.gnt", ST_DONE, 1'b1, CAUSE_ABORT, 10);
      start = 1'b1;
      step();
      start = 1'b0;
      exp_all("arb.start_ign", ST_DONE, 1'b1, CAUSE_ABORT, 10);
      ext_req = 1'b0;
      exp_all("arb.fall_lat", ST_DONE, 1'b1, CAUSE_ABORT, 10);
      step();
      exp_all("arb.release", ST_DONE, 1'b0, CAUSE_ABORT, 10);

      // Abort from PAUSE; grant keeps mirroring the held request.
      do_start(0);
      exp_all("ap.run0", ST_RUN, 1'b0, CAUSE_NONE, 0);
      ext_req = 1'b1;
      step();
      exp_all("ap.pause", ST_PAUSE, 1'b1, CAUSE_NONE, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      exp_all("ap.done", ST_DONE, 1'b1, CAUSE_ABORT, 1);
      ext_req = 1'b0;
      step();
      exp_all("ap.idle", ST_DONE, 1'b0, CAUSE_ABORT, 1);

      // Abort outranks a HALT seen in the same RUN cycle.
      do_start(0);
      exp_all("ar.run0", ST_RUN, 1'b0, CAUSE_NONE, 0);
      step();
      abort       = 1'b1;
      instruction = HALT_WORD;
      step();
      abort       = 1'b0;
      instruction = NOP_INSTR;
      exp_all("ar.done", ST_DONE, 1'b0, CAUSE_ABORT, 2);

      // Asynchronous reset mid-run clears everything before the next edge.
      do_start(0);
      step();
      step();
      exp_all("r.run2", ST_RUN, 1'b0, CAUSE_NONE, 2);
      #3;
      arst_n = 1'b0;
      #1;
      exp_all("r.async", ST_IDLE, 1'b0, CAUSE_NONE, 0);
      #10;
      arst_n = 1'b1;
      step();
      exp_all("r.post1", ST_IDLE, 1'b0, CAUSE_NONE, 0);
      step();
      exp_all("r.post2", ST_IDLE, 1'b0, CAUSE_NONE, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
